load_register: RTL and testbench

Parameterizable synchronous storage register with a load enable and an asynchronous active-low reset. It captures `data_in` on a rising clock edge when `load_en` is high and holds its value otherwise. It is the generic state-holding element used by the ALU datapath to latch operands, opcodes and results between the input interface and the compute stage.

---
 rtl/load_register.sv | 36 +++
 tb/tb_load_register.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/load_register.sv
// Generic WIDTH-bit storage register with a load enable and an asynchronous
// active-low reset. It latches operands, opcodes and results in the ALU datapath.
module load_register #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;

    // Hold is the default. When load_en is high, the next value is data_in.
    always_comb begin
        data_next = data_reg;
        if (load_en) begin
            data_next = data_in;
        end
    end

    // Reset overrides any load at a coincident edge. It clears all bits together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_reg <= RESET_VALUE;
        end else begin
            data_reg <= data_next;
        end
    end

    assign data_out = data_reg;

endmodule

// File: tb/tb_load_register.sv
// Directed self-checking bench for load_register: reset, load, hold, reload,
// asynchronous reset between edges, back-to-back loads, and a non-zero RESET_VALUE.
module tb_load_register;

    logic        clk;
    logic        reset;
    logic        load_en;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic [15:0] wide_in;
    logic [15:0] wide_out;

    int checks;
    int errors;

    load_register #(
        .WIDTH       (8),
        .RESET_VALUE (8'h00)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load_en  (load_en),
        .data_in  (data_in),
        .data_out (data_out)
    );

    load_register #(
        .WIDTH       (16),
        .RESET_VALUE (16'hBEEF)
    ) dut_wide (
        .clk      (clk),
        .reset    (reset),
        .load_en  (load_en),
        .data_in  (wide_in),
        .data_out (wide_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        load_en = 1'b0;
        data_in = 8'hAA;
        wide_in = 16'h1234;

        // Reset is asserted before any clock edge, so the flops must clear at once.
        #2 reset = 1'b0;
        #1 check("rst_async", 64'(data_out), 64'h00);
        check("rst_val_wide", 64'(wide_out), 64'hBEEF);
        @(posedge clk); #1;
        check("rst_held", 64'(data_out), 64'h00);

        // A loading edge while reset is held must not load.
        load_en = 1'b1;
        @(posedge clk); #1;
        check("rst_wins", 64'(data_out), 64'h00);
        check("rst_wins_wide", 64'(wide_out), 64'hBEEF);

        // Release reset between edges. The first edge after release loads.
        @(negedge clk);
        reset   = 1'b1;
        data_in = 8'h55;
        wide_in = 16'hC0DE;
        load_en = 1'b1;
        @(posedge clk); #1;
        check("load_55", 64'(data_out), 64'h55);
        check("load_wide", 64'(wide_out), 64'hC0DE);

        // Hold for three cycles while data_in changes.
        @(negedge clk);
        load_en = 1'b0;
        data_in = 8'hFF;
        wide_in = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold_%0d", i), 64'(data_out), 64'h55);
        end
        check("hold_wide", 64'(wide_out), 64'hC0DE);

        // Reload.
        @(negedge clk);
        data_in = 8'hA3;
        load_en = 1'b1;
        @(posedge clk); #1;
        check("reload_a3", 64'(data_out), 64'hA3);

        // Assert reset between edges. Clear is immediate, and the next loading edge is discarded.
        @(negedge clk);
        data_in = 8'h5A;
        load_en = 1'b1;
        #1 reset = 1'b0;
        #1 check("mid_rst_clear", 64'(data_out), 64'h00);
        check("mid_rst_wide", 64'(wide_out), 64'hBEEF);
        @(posedge clk); #1;
        check("mid_rst_noload", 64'(data_out), 64'h00);

        // Release reset. Load 01, 02 and 03 back to back.
        @(negedge clk);
        reset   = 1'b1;
        load_en = 1'b1;
        data_in = 8'h01;
        @(posedge clk); #1;
        check("b2b_01", 64'(data_out), 64'h01);
        @(negedge clk);
        data_in = 8'h02;
        @(posedge clk); #1;
        check("b2b_02", 64'(data_out), 64'h02);
        @(negedge clk);
        data_in = 8'h03;
        @(posedge clk); #1;
        check("b2b_03", 64'(data_out), 64'h03);

        // Drop load_en and confirm that the last value is kept.
        @(negedge clk);
        load_en = 1'b0;
        data_in = 8'hC7;
        @(posedge clk); #1;
        check("hold_after_b2b", 64'(data_out), 64'h03);

        // Reset asserted just after a loading edge must still clear the register.
        @(negedge clk);
        load_en = 1'b1;
        data_in = 8'h3C;
        @(posedge clk); #1;
        check("load_3c", 64'(data_out), 64'h3C);
        reset = 1'b0;
        #1 check("post_edge_rst", 64'(data_out), 64'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
